// File: rtl/shift_right_seq.sv
// Multi-cycle 32-bit logical/arithmetic right shifter.
// Applies one barrel stage (16, 8, 4, 2, 1) per clock behind a start/ready handshake.
//
// state | meaning
// IDLE  | waiting for ctrl_start
// SHIFT | applying stages 0..4, one per edge; busy high
// DONE  | result just published; RDY high for this cycle, may accept a new start
module shift_right_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_start,
  input  logic        ctrl_arith,
  input  logic [31:0] data_operandA,
  input  logic [4:0]  ctrl_shiftamt,
  output logic [31:0] data_result,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_next;
  logic [31:0] work;
  logic [4:0]  amt;
  logic        arith;
  logic [2:0]  stage;

  logic        accept;
  logic        last_stage;
  logic        amt_bit;
  logic [4:0]  shift_d;
  logic [31:0] srl_res;
  logic [31:0] sra_res;
  logic [31:0] stage_out;

  assign accept     = ctrl_start && ((state == IDLE) || (state == DONE));
  assign last_stage = (state == SHIFT) && (stage == 3'd4);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ctrl_start) state_next = SHIFT;
      SHIFT:   if (stage == 3'd4) state_next = DONE;
      DONE:    state_next = ctrl_start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Stage k consumes amount bit 4-k with distance 16 >> k.
  always_comb begin
    amt_bit = 1'b0;
    shift_d = 5'd0;
    case (stage)
      3'd0: begin amt_bit = amt[4]; shift_d = 5'd16; end
      3'd1: begin amt_bit = amt[3]; shift_d = 5'd8;  end
      3'd2: begin amt_bit = amt[2]; shift_d = 5'd4;  end
      3'd3: begin amt_bit = amt[1]; shift_d = 5'd2;  end
      3'd4: begin amt_bit = amt[0]; shift_d = 5'd1;  end
      default: begin amt_bit = 1'b0; shift_d = 5'd0; end
    endcase
  end

  // Kept as separate statements so the signed shift is not forced unsigned by a mixed ternary.
  always_comb srl_res = work >> shift_d;
  always_comb sra_res = $signed(work) >>> shift_d;

  always_comb begin
    stage_out = work;
    if (amt_bit) stage_out = arith ? sra_res : srl_res;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      work  <= 32'd0;
      amt   <= 5'd0;
      arith <= 1'b0;
      stage <= 3'd0;
    end else if (accept) begin
      work  <= data_operandA;
      amt   <= ctrl_shiftamt;
      arith <= ctrl_arith;
      stage <= 3'd0;
    end else if (state == SHIFT) begin
      work  <= stage_out;
      stage <= stage + 3'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_result    <= 32'd0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= last_stage;
      busy           <= (state_next == SHIFT);
      if (last_stage) data_result <= stage_out;
    end
  end

endmodule

// File: tb/tb_shift_right_seq.sv
// Directed bench for shift_right_seq: latency, fill modes, ignored starts,
// back-to-back issue and asynchronous reset mid-operation.
module tb_shift_right_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_start;
  logic        ctrl_arith;
  logic [31:0] data_operandA;
  logic [4:0]  ctrl_shiftamt;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        busy;

  int checks = 0;
  int errors = 0;

  shift_right_seq dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_start     (ctrl_start),
    .ctrl_arith     (ctrl_arith),
    .data_operandA  (data_operandA),
    .ctrl_shiftamt  (ctrl_shiftamt),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a request so it is sampled on the next rising edge (E0), then return just after E0.
  task automatic issue(input logic [31:0] a, input logic [4:0] amt, input logic ar);
    @(negedge clock);
    ctrl_start    = 1'b1;
    data_operandA = a;
    ctrl_shiftamt = amt;
    ctrl_arith    = ar;
    @(posedge clock);
    #1;
    ctrl_start    = 1'b0;
    data_operandA = ~a;
    ctrl_shiftamt = ~amt;
    ctrl_arith    = ~ar;
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [4:0] amt,
                       input logic ar, input logic [31:0] exp);
    issue(a, amt, ar);
    check({tag, " busy@E0"}, busy, 1);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clock); #1;
      check({tag, " rdy early"}, data_resultRDY, 0);
      check({tag, " busy mid"}, busy, 1);
    end
    @(posedge clock); #1;
    check({tag, " rdy@E5"}, data_resultRDY, 1);
    check({tag, " busy@E5"}, busy, 0);
    check({tag, " result"}, data_result, exp);
    @(posedge clock); #1;
    check({tag, " rdy@E6"}, data_resultRDY, 0);
    check({tag, " hold"}, data_result, exp);
  endtask

  initial begin
    int pulses;
    int first_edge;
    logic [31:0] first_res;

    reset = 1'b0; ctrl_start = 1'b0; ctrl_arith = 1'b0;
    data_operandA = 32'd0; ctrl_shiftamt = 5'd0;
    #1 reset = 1'b1;
    #2;
    check("reset result", data_result, 0);
    check("reset rdy", data_resultRDY, 0);
    check("reset busy", busy, 0);
    @(negedge clock); reset = 1'b0;
    repeat (3) @(posedge clock);
    #1 check("idle busy", busy, 0);

    do_op("lsr4",      32'h8000_0000, 5'd4,  1'b0, 32'h0800_0000);
    do_op("asr31neg",  32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF);
    do_op("lsr31",     32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001);
    do_op("asr31pos",  32'h7FFF_FFFF, 5'd31, 1'b1, 32'h0000_0000);
    do_op("amt0",      32'h1234_5678, 5'd0,  1'b0, 32'h1234_5678);
    do_op("asr21",     32'hF000_0000, 5'd21, 1'b1, 32'hFFFF_FF80);
    do_op("lsr21",     32'hF000_0000, 5'd21, 1'b0, 32'h0000_0780);

    // Start re-asserted while in SHIFT must be dropped.
    issue(32'h0000_0100, 5'd8, 1'b0);
    @(posedge clock);
    @(negedge clock);
    ctrl_start = 1'b1; data_operandA = 32'hFFFF_FFFF; ctrl_shiftamt = 5'd0;
    @(posedge clock); #1;
    ctrl_start = 1'b0;
    pulses = 0; first_edge = -1; first_res = 32'd0;
    for (int e = 3; e <= 14; e++) begin
      @(posedge clock); #1;
      if (data_resultRDY) begin
        if (pulses == 0) begin first_edge = e; first_res = data_result; end
        pulses++;
      end
    end
    check("busy-start pulses", pulses, 1);
    check("busy-start edge", first_edge, 5);
    check("busy-start result", first_res, 32'h0000_0001);

    // Back-to-back: second start presented during the DONE cycle.
    issue(32'h0000_0040, 5'd2, 1'b0);
    repeat (4) @(posedge clock);
    @(posedge clock); #1;
    check("b2b rdy1", data_resultRDY, 1);
    check("b2b res1", data_result, 32'h0000_0010);
    ctrl_start = 1'b1; data_operandA = 32'h8000_0000; ctrl_shiftamt = 5'd1; ctrl_arith = 1'b1;
    @(posedge clock); #1;
    ctrl_start = 1'b0; data_operandA = 32'd0; ctrl_arith = 1'b0;
    check("b2b busy@E6", busy, 1);
    check("b2b rdy@E6", data_resultRDY, 0);
    repeat (3) @(posedge clock);
    @(posedge clock); #1;
    check("b2b rdy@E10", data_resultRDY, 0);
    @(posedge clock); #1;
    check("b2b rdy2", data_resultRDY, 1);
    check("b2b res2", data_result, 32'hC000_0000);

    // Asynchronous reset between edges during SHIFT.
    issue(32'hFFFF_0000, 5'd16, 1'b0);
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("rst mid result", data_result, 0);
    check("rst mid busy", busy, 0);
    check("rst mid rdy", data_resultRDY, 0);
    @(negedge clock); reset = 1'b0;
    pulses = 0;
    for (int e = 0; e < 8; e++) begin
      @(posedge clock); #1;
      if (data_resultRDY) pulses++;
    end
    check("rst no pulse", pulses, 0);
    check("rst idle busy", busy, 0);
    do_op("post-rst lsr", 32'hFFFF_0000, 5'd16, 1'b0, 32'h0000_FFFF);
    do_op("post-rst asr", 32'hFFFF_0000, 5'd16, 1'b1, 32'hFFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got still running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
